// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the data-memory responder:
// access-size encodings (funct3), responder FSM states and error classes.
package rv32i_pkg;

    localparam logic [2:0] SIZE_B = 3'b000;
    localparam logic [2:0] SIZE_H = 3'b001;
    localparam logic [2:0] SIZE_W = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

    // Error classes in check priority order; the bus only carries err != ERR_NONE.
    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_SIZE,
        ERR_ALIGN,
        ERR_RANGE
    } dmem_err_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the memory stage and the data-memory responder.
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian byte-lane steering: sign-extended load extraction, store
// merge into the existing word, and natural-alignment check.
module dmem_lane_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o,
    output logic        misaligned_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel     = word_i[{addr_lo_i, 3'b000} +: 8];
        half_sel     = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        load_o       = '0;
        store_o      = word_i;
        misaligned_o = 1'b0;
        case (size_i)
            SIZE_B: begin
                load_o                              = {{24{byte_sel[7]}}, byte_sel};
                store_o[{addr_lo_i, 3'b000} +: 8]   = wdata_i[7:0];
            end
            SIZE_H: begin
                misaligned_o = addr_lo_i[0];
                load_o       = {{16{half_sel[15]}}, half_sel};
                if (addr_lo_i[1]) store_o[31:16] = wdata_i[15:0];
                else              store_o[15:0]  = wdata_i[15:0];
            end
            SIZE_W: begin
                misaligned_o = |addr_lo_i;
                load_o       = word_i;
                store_o      = wdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accept, wait LATENCY cycles,
// perform the access on a word array, then hold the response until taken.
module dmem_responder
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_responder_if.slave   bus
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    logic [31:0]      word_rd, load_data, store_word;
    logic             misaligned, access, mem_we;
    dmem_err_e        err_code;

    assign idx     = addr_q[IDX_W+1:2];
    assign word_rd = mem[idx];

    dmem_lane_align u_align (
        .size_i       (size_q),
        .addr_lo_i    (addr_q[1:0]),
        .word_i       (word_rd),
        .wdata_i      (wdata_q),
        .load_o       (load_data),
        .store_o      (store_word),
        .misaligned_o (misaligned)
    );

    always_comb begin
        if (!(size_q inside {SIZE_B, SIZE_H, SIZE_W})) err_code = ERR_SIZE;
        else if (misaligned)                             err_code = ERR_ALIGN;
        else if (addr_q[31:2] >= 30'(DEPTH_WORDS))       err_code = ERR_RANGE;
        else                                             err_code = ERR_NONE;
    end

    assign access = (state_q == WAIT) && (cnt_q == '0);
    assign mem_we = access && we_q && (err_code == ERR_NONE);

    // Array is deliberately not reset; contents are defined only once written.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= store_word;
    end

    assign bus.req_ready = rst_n && (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    // Every request passes through WAIT (counter starts at LATENCY-1, access at 0),
    // so the response always appears LATENCY edges after acceptance, LATENCY=1 included.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (access) begin
                    err_d   = (err_code != ERR_NONE);
                    rdata_d = (!we_q && err_code == ERR_NONE) ? load_data : '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-addressed reference memory with a per-cycle
// protocol/response checker, directed scenarios and randomized traffic.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc   = 0;
    int          checks = 0;
    int          errors = 0;

    dmem_responder_if bus();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk32(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic void chk1(string name, logic got, logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic void fail_to(string name);
        checks++;
        errors++;
        $display("FAIL %s timed out (cycle %0d)", name, cyc);
    endfunction

    // Reference memory: one entry per written byte address.
    logic [7:0] mb [int unsigned];

    function automatic void model_access(input logic we, input logic [2:0] size,
                                         input logic [31:0] addr, input logic [31:0] wdata,
                                         output logic [31:0] rd, output bit err, output bit known);
        int unsigned n;
        logic [31:0] v;
        n     = (size == 3'd0) ? 1 : (size == 3'd1) ? 2 : 4;
        err   = (size > 3'd2) || (addr % n != 0) || (addr / 4 >= DEPTH);
        rd    = '0;
        known = 1'b1;
        v     = '0;
        if (!err && !we) begin
            for (int unsigned i = 0; i < n; i++) begin
                if (mb.exists(addr + i)) v = v | (32'(mb[addr + i]) << (8 * i));
                else known = 1'b0;
            end
            if (n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
            rd = v;
        end
        if (!err && we)
            for (int unsigned i = 0; i < n; i++) mb[addr + i] = 8'(wdata >> (8 * i));
    endfunction

    bit          busy = 1'b0, committed = 1'b0;
    logic        t_we;
    logic [2:0]  t_size;
    logic [31:0] t_addr, t_wdata;
    int unsigned t_acc;
    logic [31:0] e_rd;
    bit          e_err, e_known;
    int unsigned acc_cyc = 0, vis_cyc = 0, hs_cyc = 0, acc_cnt = 0, done_cnt = 0;
    logic [31:0] got_rd;
    logic        got_err;

    // Checker: the transaction takes effect LAT edges after acceptance; a reset
    // before that point drops it.
    always @(negedge clk) begin
        if (busy && !committed && cyc >= t_acc + LAT) begin
            model_access(t_we, t_size, t_addr, t_wdata, e_rd, e_err, e_known);
            committed = 1'b1;
            vis_cyc   = cyc;
        end
        if (!rst_n) begin
            chk1("rst_req_ready", bus.req_ready, 1'b0);
            chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
            chk32("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
            chk1("rst_rsp_err", bus.rsp_err, 1'b0);
            busy = 1'b0;
        end else if (!busy) begin
            chk1("idle_req_ready", bus.req_ready, 1'b1);
            chk1("idle_rsp_valid", bus.rsp_valid, 1'b0);
            if (bus.req_valid) begin
                busy = 1'b1; committed = 1'b0;
                t_we = bus.req_we; t_size = bus.req_size;
                t_addr = bus.req_addr; t_wdata = bus.req_wdata;
                t_acc = cyc + 1; acc_cyc = t_acc; acc_cnt++;
            end
        end else begin
            chk1("busy_req_ready", bus.req_ready, 1'b0);
            if (!committed) chk1("wait_rsp_valid", bus.rsp_valid, 1'b0);
            else begin
                chk1("rsp_valid", bus.rsp_valid, 1'b1);
                chk1("rsp_err", bus.rsp_err, e_err);
                if (e_known) chk32("rsp_rdata", bus.rsp_rdata, e_rd);
                if (bus.rsp_ready) begin
                    got_rd = bus.rsp_rdata; got_err = bus.rsp_err;
                    hs_cyc = cyc + 1; done_cnt++; busy = 1'b0;
                end
            end
        end
    end

    task automatic drive_req(input logic we, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
        bus.req_addr = addr;  bus.req_wdata = wdata;
    endtask

    task automatic wait_accept();
        int unsigned a0 = acc_cnt;
        for (int i = 0; i < 64 && acc_cnt == a0; i++) @(posedge clk);
        if (acc_cnt == a0) fail_to("accept");
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_size  = 3'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
    endtask

    task automatic finish_rsp(input int unsigned hold, input bit early);
        int unsigned d0 = done_cnt;
        if (!early) begin
            for (int i = 0; i < 64; i++) begin
                @(negedge clk);
                if (bus.rsp_valid) break;
            end
            @(posedge clk); #1;
            repeat (hold) begin @(posedge clk); #1; end
        end
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 64 && done_cnt == d0; i++) @(posedge clk);
        if (done_cnt == d0) fail_to("response");
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input int unsigned hold, input bit early);
        drive_req(we, size, addr, wdata);
        wait_accept();
        finish_rsp(hold, early);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    logic [31:0] ld_exp [6];
    logic [31:0] ld_addr [6];
    logic [2:0]  ld_size [6];

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Word store then load, with latency pinned.
        txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 1'b0);
        chk32("st_latency", 32'(vis_cyc - acc_cyc), 32'd2);
        chk32("st_rdata", got_rd, 32'd0);
        chk1("st_err", got_err, 1'b0);
        txn(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0);
        chk32("ld_word_10", got_rd, 32'hDEADBEEF);

        // Sign-extended byte/half loads.
        txn(1'b1, 3'b010, 32'h20, 32'h80FF7F01, 1, 1'b0);
        ld_addr = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h20, 32'h22};
        ld_size = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001};
        ld_exp  = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80,
                    32'h00007F01, 32'hFFFF80FF};
        for (int i = 0; i < 6; i++) begin
            txn(1'b0, ld_size[i], ld_addr[i], 32'h0, 0, 1'b0);
            chk32($sformatf("ld_lane_%0d", i), got_rd, ld_exp[i]);
        end

        // Byte store preserves the other lanes.
        txn(1'b1, 3'b010, 32'h20, 32'h11223344, 0, 1'b0);
        txn(1'b1, 3'b000, 32'h21, 32'hFFFFFFAA, 0, 1'b1);
        txn(1'b0, 3'b010, 32'h20, 32'h0, 0, 1'b0);
        chk32("byte_merge", got_rd, 32'h1122AA44);

        // Error cases leave the array untouched.
        txn(1'b1, 3'b010, 32'h04, 32'hCAFEF00D, 0, 1'b0);
        txn(1'b0, 3'b001, 32'h03, 32'h0, 0, 1'b0);
        chk1("err_half_mis", got_err, 1'b1);
        chk32("err_half_rd", got_rd, 32'd0);
        txn(1'b0, 3'b010, 32'h06, 32'h0, 0, 1'b0);
        chk1("err_word_mis", got_err, 1'b1);
        txn(1'b1, 3'b011, 32'h04, 32'h12345678, 0, 1'b0);
        chk1("err_size", got_err, 1'b1);
        txn(1'b1, 3'b010, DEPTH * 4, 32'h87654321, 0, 1'b0);
        chk1("err_range", got_err, 1'b1);
        txn(1'b0, 3'b010, DEPTH * 4, 32'h0, 0, 1'b0);
        chk32("err_range_rd", got_rd, 32'd0);
        txn(1'b0, 3'b010, 32'h04, 32'h0, 0, 1'b0);
        chk32("err_no_write", got_rd, 32'hCAFEF00D);

        // Backpressure with a competing request presented during RESP.
        drive_req(1'b0, 3'b010, 32'h10, 32'h0);
        wait_accept();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
        end
        @(posedge clk); #1;
        drive_req(1'b0, 3'b010, 32'h20, 32'h0);
        repeat (4) begin @(posedge clk); #1; end
        finish_rsp(0, 1'b1);
        chk32("bp_first_rd", got_rd, 32'hDEADBEEF);
        wait_accept();
        chk32("bp_accept_gap", 32'(acc_cyc - hs_cyc), 32'd1);
        finish_rsp(0, 1'b0);
        chk32("bp_second_rd", got_rd, 32'h1122AA44);

        // Reset during WAIT drops the pending store.
        txn(1'b1, 3'b010, 32'h40, 32'h0, 0, 1'b0);
        drive_req(1'b1, 3'b010, 32'h40, 32'h55);
        wait_accept();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk1("post_rst_valid", bus.rsp_valid, 1'b0);
        chk1("post_rst_ready", bus.req_ready, 1'b1);
        @(posedge clk); #1;
        txn(1'b0, 3'b010, 32'h40, 32'h0, 0, 1'b0);
        chk32("rst_drop_store", got_rd, 32'h0);

        // Randomized traffic over a small window plus out-of-range hits.
        for (int unsigned a = 0; a < 128; a += 4)
            txn(1'b1, 3'b010, a, $urandom, $urandom_range(0, 2), 1'b0);
        for (int i = 0; i < 300; i++) begin
            logic [2:0]  sz;
            logic [31:0] ad;
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            ad = ($urandom_range(0, 15) == 0) ? DEPTH * 4 + $urandom_range(0, 63)
                                              : $urandom_range(0, 127);
            txn(1'($urandom), sz, ad, $urandom, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
